// File: rtl/ascon_pack.sv
// Shared types and padding constants for the ASCON byte packer.
package ascon_pack;
   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PRESENT,
      DONE,
      ERROR
   } type_packer_state;

   localparam logic [7:0]  PAD_BYTE  = 8'h80;
   localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;
endpackage

// File: rtl/ascon_byte_lane_writer.sv
// Inserts a byte big-endian at lane idx_i and, when pad_i, the 10* pad byte at idx_i+1.
// Purely combinational; lanes beyond the pad byte pass through unchanged.
module ascon_byte_lane_writer
   import ascon_pack::*;
(
   input  logic [63:0] word_i,
   input  logic [7:0]  byte_i,
   input  logic [2:0]  idx_i,
   input  logic        pad_i,
   output logic [63:0] word_o
);

   always_comb begin
      word_o = word_i;
      for (int k = 0; k < 8; k++) begin
         if (idx_i == 3'(k)) begin
            word_o[63-8*k -: 8] = byte_i;
         end else if (pad_i && (k > 0) && (idx_i == 3'(k - 1))) begin
            word_o[63-8*k -: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/ascon_data_packer.sv
// Packs a byte stream into padded 64-bit blocks for the ASCON core; a block is valid the cycle
// after its last byte and is held until data_ack_i; bytes are refused while a block is pending.
module ascon_data_packer
   import ascon_pack::*;
#(
   parameter int unsigned MAX_BLOCKS = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   input  logic        byte_last_i,
   output logic        byte_ready_o,
   output logic        start_o,
   output logic [63:0] data_o,
   output logic        data_valid_o,
   input  logic        data_ack_i,
   output logic [3:0]  block_cnt_o,
   output logic        done_o,
   output logic        error_o
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_BLOCKS);

   type_packer_state state_q, state_d;
   logic [63:0] buf_q, buf_d;
   logic [2:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        final_q, final_d;
   logic        pad_pending_q, pad_pending_d;
   logic        gap_q, gap_d;
   logic [63:0] lane_word;

   ascon_byte_lane_writer u_lane_writer (
      .word_i (buf_q),
      .byte_i (byte_i),
      .idx_i  (idx_q),
      .pad_i  (byte_last_i),
      .word_o (lane_word)
   );

   assign data_o      = buf_q;
   assign block_cnt_o = cnt_q;

   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      final_d       = final_q;
      pad_pending_d = pad_pending_q;
      gap_d         = 1'b0;
      byte_ready_o  = 1'b0;
      start_o       = 1'b0;
      data_valid_o  = 1'b0;
      done_o        = 1'b0;
      error_o       = 1'b0;

      case (state_q)
         IDLE, ERROR: begin
            error_o = (state_q == ERROR);
            if (start_i && !reset_i) begin
               start_o       = 1'b1;
               buf_d         = '0;
               idx_d         = '0;
               cnt_d         = '0;
               final_d       = 1'b0;
               pad_pending_d = 1'b0;
               state_d       = FILL;
            end
         end
         FILL: begin
            if (cnt_q >= MAX_CNT) begin
               state_d = ERROR;
            end else begin
               byte_ready_o = 1'b1;
               if (byte_valid_i) begin
                  buf_d = lane_word;
                  if (byte_last_i) begin
                     state_d = PRESENT;
                     // A full last block has no room for the pad byte, so a pad-only block follows.
                     if (idx_q == 3'd7) pad_pending_d = 1'b1;
                     else               final_d       = 1'b1;
                  end else if (idx_q == 3'd7) begin
                     state_d = PRESENT;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
         end
         PRESENT: begin
            data_valid_o = !gap_q;
            if (!gap_q && data_ack_i) begin
               cnt_d = cnt_q + 4'd1;
               if (final_q) begin
                  state_d = DONE;
               end else if (pad_pending_q) begin
                  if (cnt_d == MAX_CNT) begin
                     state_d = ERROR;
                  end else begin
                     buf_d         = PAD_BLOCK;
                     final_d       = 1'b1;
                     pad_pending_d = 1'b0;
                     gap_d         = 1'b1;
                  end
               end else begin
                  buf_d   = '0;
                  idx_d   = '0;
                  state_d = FILL;
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         buf_q         <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         final_q       <= 1'b0;
         pad_pending_q <= 1'b0;
         gap_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         final_q       <= final_d;
         pad_pending_q <= pad_pending_d;
         gap_q         <= gap_d;
      end
   end

endmodule

// File: tb/tb_ascon_data_packer.sv
// Randomised and directed scoreboard bench for ascon_data_packer (MAX_BLOCKS 4 and 2 instances).
module tb_ascon_data_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, vld = 1'b0, last = 1'b0, ack = 1'b0, sel = 1'b0;
   logic [7:0] bdat = 8'h00;

   logic d1_start, d1_rdy, d1_dv, d1_done, d1_err;
   logic d2_start, d2_rdy, d2_dv, d2_done, d2_err;
   logic [63:0] d1_data, d2_data;
   logic [3:0]  d1_cnt, d2_cnt;

   logic obs_start, obs_rdy, obs_dv, obs_done, obs_err;
   logic [63:0] obs_data;
   logic [3:0]  obs_cnt;

   assign obs_start = sel ? d2_start : d1_start;
   assign obs_rdy   = sel ? d2_rdy   : d1_rdy;
   assign obs_dv    = sel ? d2_dv    : d1_dv;
   assign obs_done  = sel ? d2_done  : d1_done;
   assign obs_err   = sel ? d2_err   : d1_err;
   assign obs_data  = sel ? d2_data  : d1_data;
   assign obs_cnt   = sel ? d2_cnt   : d1_cnt;

   ascon_data_packer #(.MAX_BLOCKS(4)) dut (
      .clock_i(clk), .reset_i(rst), .start_i(start & ~sel),
      .byte_i(bdat), .byte_valid_i(vld & ~sel), .byte_last_i(last),
      .byte_ready_o(d1_rdy), .start_o(d1_start), .data_o(d1_data),
      .data_valid_o(d1_dv), .data_ack_i(ack & ~sel), .block_cnt_o(d1_cnt),
      .done_o(d1_done), .error_o(d1_err)
   );

   ascon_data_packer #(.MAX_BLOCKS(2)) dut2 (
      .clock_i(clk), .reset_i(rst), .start_i(start & sel),
      .byte_i(bdat), .byte_valid_i(vld & sel), .byte_last_i(last),
      .byte_ready_o(d2_rdy), .start_o(d2_start), .data_o(d2_data),
      .data_valid_o(d2_dv), .data_ack_i(ack & sel), .block_cnt_o(d2_cnt),
      .done_o(d2_done), .error_o(d2_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      bit          gap1;
   } exp_t;

   exp_t exp_q[$];
   int n_vec = 0, n_err = 0, done_seen = 0, last_nexp = 0;
   int ack_stall = -1;
   bit ack_en = 1'b0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_evt(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: expected event did not occur within its bound", nm);
   endtask

   // Acknowledge a presented block after ack_stall cycles (random 0..3 when negative).
   initial begin
      int vc = 0;
      int st = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_en) begin
            if (obs_dv && !rst) begin
               if (vc >= st) ack = 1'b1;
               else vc++;
            end else begin
               ack = 1'b0;
               vc  = 0;
               st  = (ack_stall < 0) ? int'($urandom_range(0, 3)) : ack_stall;
            end
         end
      end
   end

   // Monitor: pops expected blocks on each handshake and checks hold / gap behaviour.
   initial begin
      bit pv = 1'b0, pa = 1'b0, gp = 1'b0;
      logic [63:0] pd = '0;
      int since = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0; pa = 1'b0; since = 0;
            continue;
         end
         if (pv && !pa) chk("hold_until_ack", {obs_dv, obs_data}, {1'b1, pd});
         if (since == 1) chk("valid_drop_after_ack", obs_dv, 0);
         if (since == 2 && gp) chk("pad_block_after_one_cycle", obs_dv, 1);
         since = (since == 1) ? 2 : 0;
         if (obs_dv) chk("ready_low_in_present", obs_rdy, 0);
         if (obs_dv && ack) begin
            if (exp_q.size() == 0) begin
               fail_evt("no_unexpected_block");
            end else begin
               e = exp_q.pop_front();
               chk("block_data", obs_data, e.data);
               gp = e.gap1;
               since = 1;
            end
         end
         if (obs_done) done_seen++;
         pv = obs_dv; pa = ack; pd = obs_data;
      end
   end

   // All driving tasks start and end at posedge+1.
   task automatic do_start();
      done_seen = 0;
      start = 1'b1;
      @(negedge clk);
      chk("start_pulse", obs_start, 1);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_single_cycle_error_clear", {obs_start, obs_err}, 0);
      @(posedge clk); #1;
   endtask

   task automatic put_byte(input logic [7:0] b, input bit l, output bit abort);
      int t = 0;
      bdat = b; last = l; vld = 1'b1; abort = 1'b0;
      while (1) begin
         @(negedge clk);
         if (obs_rdy) break;
         if (obs_err) begin abort = 1'b1; break; end
         t++;
         if (t > 300) begin fail_evt("byte_ready_timeout"); abort = 1'b1; break; end
      end
      @(posedge clk); #1;
      vld = 1'b0; last = 1'b0;
   endtask

   // Reference: append 0x80, zero-fill to 8-byte multiple, split big-endian, cap at MAX blocks.
   task automatic send_msg(input logic [7:0] msg[$], input int gapmode, input int poke_at);
      int maxb = sel ? 2 : 4;
      logic [7:0] p[$];
      int nb, nexp, t;
      bit experr, ab;
      logic [63:0] w;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 8 != 0) p.push_back(8'h00);
      nb = p.size() / 8;
      nexp = (nb > maxb) ? maxb : nb;
      experr = (nb > maxb);
      for (int b = 0; b < nexp; b++) begin
         w = '0;
         for (int j = 0; j < 8; j++) w = {w[55:0], p[8*b+j]};
         exp_q.push_back('{data: w,
                           gap1: (msg.size() % 8 == 0) && (b + 1 == nb - 1) && (b + 1 < nexp)});
      end
      do_start();
      for (int i = 0; i < msg.size(); i++) begin
         if (i == poke_at) begin
            start = 1'b1;
            @(negedge clk);
            chk("start_ignored_in_fill", obs_start, 0);
            @(posedge clk); #1;
            start = 1'b0;
         end
         if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 1) == 1)) begin
            @(posedge clk); #1;
         end
         put_byte(msg[i], i == msg.size() - 1, ab);
         if (ab) break;
      end
      t = 0;
      while (t < 1000) begin
         @(negedge clk);
         if (obs_done || obs_err) break;
         t++;
      end
      if (t >= 1000) fail_evt("message_end_timeout");
      repeat (2) @(negedge clk);
      chk("block_cnt", obs_cnt, nexp);
      chk("error_flag", obs_err, experr);
      chk("done_pulses", done_seen, experr ? 0 : 1);
      chk("scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
      last_nexp = nexp;
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m[$];
      bit ab;
      int t;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {obs_start, obs_rdy, obs_dv, obs_data, obs_cnt, obs_done, obs_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      ack_en = 1'b1;

      // Short message with four stall cycles before the acknowledge.
      ack_stall = 4;
      m = '{8'h41, 8'h42, 8'h43};
      send_msg(m, 0, -1);

      // Reset held three cycles while a block is presented.
      ack_en = 1'b0; ack = 1'b0;
      do_start();
      put_byte(8'h11, 1'b1, ab);
      t = 0;
      while (t < 20 && !obs_dv) begin @(negedge clk); t++; end
      if (!obs_dv) fail_evt("valid_before_reset");
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("reset_mid_present", {obs_start, obs_rdy, obs_dv, obs_data, obs_cnt, obs_done, obs_err}, 0);
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_after_reset_no_done", {obs_rdy, obs_dv, obs_done}, 0);
      end
      @(posedge clk); #1;
      ack_en = 1'b1; ack_stall = -1;

      // Full 8-byte message followed by a pad-only block.
      m = {};
      for (int i = 0; i < 8; i++) m.push_back(8'(i));
      send_msg(m, 0, -1);

      // Twelve bytes with byte_valid_i toggling.
      m = {};
      for (int i = 0; i < 12; i++) m.push_back(8'(i));
      send_msg(m, 1, -1);

      // Bytes and acknowledge in IDLE are ignored.
      ack_en = 1'b0;
      vld = 1'b1; bdat = 8'h55; last = 1'b1; ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ignores_inputs", {obs_rdy, obs_dv, obs_start, obs_done, obs_cnt}, {4'b0000, 4'(last_nexp)});
      end
      @(posedge clk); #1;
      vld = 1'b0; last = 1'b0; ack = 1'b0; ack_en = 1'b1;

      // start_i raised during FILL of the second block.
      m = {};
      for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
      send_msg(m, 0, 9);

      // Overflow on the two-block instance, then restart from ERROR.
      sel = 1'b1;
      m = {};
      for (int i = 0; i < 16; i++) m.push_back(8'(i));
      send_msg(m, 0, -1);
      m = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      send_msg(m, 2, -1);
      for (int r = 0; r < 6; r++) begin
         m = {};
         for (int i = 0; i < int'($urandom_range(1, 20)); i++) m.push_back(8'($urandom));
         send_msg(m, 2, -1);
      end
      sel = 1'b0;

      for (int r = 0; r < 25; r++) begin
         m = {};
         for (int i = 0; i < int'($urandom_range(1, 40)); i++) m.push_back(8'($urandom));
         send_msg(m, 2, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ascon_data_packer.md
Name: ascon_data_packer

Overview:
- Upstream feeder for the ASCON-128 top level. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 64-bit blocks.
- Applies ASCON 10* padding to the final block and presents each block to the core as data/data_valid.
- Holds each block until the core acknowledges it (acknowledge is driven from the core's cipher_valid).
- Pulses start toward the core at the beginning of every message.

Parameters:
MAX_BLOCKS, 4, maximum 64-bit blocks per message, padding block included (range 1..15, matches the core's 4-bit block counter)

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  synchronous reset, active-high
start_i  in  1  begin a new message (sampled in IDLE and ERROR only)
byte_i  in  8  message byte
byte_valid_i  in  1  byte_i valid
byte_last_i  in  1  byte_i is the final message byte (qualified by byte_valid_i)
byte_ready_o  out  1  packer accepts a byte this cycle
start_o  out  1  one-cycle start pulse to the core
data_o  out  64  packed/padded block to the core
data_valid_o  out  1  data_o valid; held until data_ack_i
data_ack_i  in  1  core consumed the block (cipher_valid)
block_cnt_o  out  4  blocks acknowledged in the current message
done_o  out  1  one-cycle pulse after the final block is acknowledged
error_o  out  1  block overflow; held high until start_i or reset

Behaviour:
- Reset: state IDLE. All outputs 0, data_o = 64'h0, byte index = 0, final/pad_pending flags = 0. Reset mid-message aborts immediately, with no done_o pulse.
- A byte transfers when byte_valid_i && byte_ready_o. Byte k (k = 0..7) of a block lands at data_o[63-8k -: 8].
- IDLE: byte_ready_o = 0. On start_i: clear buffer, index, block_cnt and flags; start_o = 1 for that cycle; next state FILL.
- FILL: byte_ready_o = 1 while block_cnt_o < MAX_BLOCKS.
  - If block_cnt_o == MAX_BLOCKS on entry: byte_ready_o = 0, go to ERROR.
  - Byte accepted, not last, index < 7: index++.
  - Byte accepted, not last, index == 7: go to PRESENT.
  - Byte accepted with byte_last_i, index < 7: write 8'h80 at index+1; remaining bytes stay 0; set final; go to PRESENT.
  - Byte accepted with byte_last_i, index == 7: set pad_pending; go to PRESENT.
- PRESENT: data_valid_o = 1 and data_o stable until data_ack_i. On data_ack_i, block_cnt++, then:
  - final set: go to DONE.
  - pad_pending set: if the incremented count == MAX_BLOCKS go to ERROR; otherwise load 64'h8000_0000_0000_0000, set final, clear pad_pending, stay in PRESENT. data_valid_o drops for exactly one cycle between the two blocks.
  - neither: clear buffer and index, go to FILL.
- data_ack_i outside PRESENT is ignored.
- DONE: done_o = 1 for one cycle, then IDLE. block_cnt_o holds its value until the next start_i.
- ERROR: error_o = 1, byte_ready_o = 0, data_valid_o = 0. start_i behaves as in IDLE (restarts the message) and clears error_o.
- start_i in FILL, PRESENT or DONE is ignored.
- Latency: the last byte of a block is accepted at edge N; data_valid_o = 1 from cycle N+1.
- Zero-length messages are not supported: every message carries at least one byte with byte_last_i.

Decomposition:
- Package ascon_pack gets:
  - typedef type_packer_state (IDLE, FILL, PRESENT, DONE, ERROR)
  - constant PAD_BYTE = 8'h80
  - constant PAD_BLOCK = 64'h8000_0000_0000_0000
- One sub-module, ascon_byte_lane_writer: combinational insertion of a byte plus optional pad byte at an index into a 64-bit word.
- FSM, counters and registers stay in ascon_data_packer.

Test Plan:
- Reset held 3 cycles mid-PRESENT -> all outputs 0, state IDLE, no done_o.
- start_i, then 3 bytes 0x41,0x42,0x43 with last on 0x43 -> start_o pulse; data_o = 64'h4142_4380_0000_0000; data_valid_o held through 4 stall cycles until data_ack_i; block_cnt_o = 1; done_o pulse.
- 8 bytes 0x00..0x07, last on 0x07 -> block 64'h0001_0203_0405_0607, then after ack a block 64'h8000_0000_0000_0000; block_cnt_o = 2; done_o once.
- 12 bytes with byte_valid_i toggling every other cycle -> blocks 64'h0001..07 and 64'h0809_0A0B_8000_0000; byte_ready_o = 0 throughout PRESENT.
- MAX_BLOCKS = 2, 16 bytes, last on byte 15 -> two data blocks acked, no pad block, error_o = 1; then start_i -> error_o = 0, start_o pulse.
- Bytes or data_ack_i driven in IDLE, and start_i driven during FILL -> no state change, no start_o, block_cnt_o unchanged.
